// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the writeback path.
package regfile_pkg;
  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NUM_REGS = 32;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wr_req_t;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after i_ptr, wrapping; one-hot grant.
// Purely combinational, zero latency; no requests gives an all-zero grant.
module rr_arbiter #(
  parameter int W  = 2,
  parameter int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [W-1:0]  o_gnt
);
  int   w_idx;
  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < W; i++) begin
      w_idx = int'(i_ptr) + i;
      if (w_idx >= W) w_idx = w_idx - W;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates writeback requesters onto the single register-file write port and keeps the busy scoreboard.
// Grant (ready) is combinational; the write is registered one cycle; a stalled requester simply holds valid.
module regfile_write_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int AW           = regfile_pkg::AW,
  parameter int DW           = regfile_pkg::DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ-1:0][AW-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0][DW-1:0] i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic                       i_claim_valid,
  input  logic [AW-1:0]              i_claim_addr,
  input  logic                       i_flush,
  output logic                       o_we3,
  output logic [AW-1:0]              o_a3,
  output logic [DW-1:0]              o_wd3,
  output logic [2**AW-1:0]           o_busy
);
  localparam int         NLO        = NUM_REQ - 1;
  localparam int         LPW        = (NLO > 1) ? $clog2(NLO) : 1;
  localparam logic [3:0] WAIT_MAX   = 4'd15;
  localparam logic [3:0] STARVE_THR = 4'(STARVE_LIMIT);

  // Pointer is stored as an offset from requester 1, so reset value 0 means requester 1.
  logic [LPW-1:0]     r_ptr;
  logic [3:0]         r_wait [NLO];
  logic               r_we3;
  logic [AW-1:0]      r_a3;
  logic [DW-1:0]      r_wd3;
  logic [2**AW-1:0]   r_busy;

  logic [NLO-1:0]     w_lo_vld, w_starved, w_oldest, w_rr_gnt, w_st_gnt;
  logic [3:0]         w_max_wait;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;
  logic [AW-1:0]      w_sel_addr;
  logic [DW-1:0]      w_sel_data;
  logic [LPW-1:0]     w_ptr_nxt;
  logic [2**AW-1:0]   w_busy_nxt;

  assign w_lo_vld = i_req_valid[NUM_REQ-1:1];

  always_comb begin
    w_starved  = '0;
    w_oldest   = '0;
    w_max_wait = '0;
    for (int k = 0; k < NLO; k++) begin
      w_starved[k] = w_lo_vld[k] && (r_wait[k] >= STARVE_THR);
      if (w_starved[k] && (r_wait[k] > w_max_wait)) w_max_wait = r_wait[k];
    end
    for (int k = 0; k < NLO; k++)
      w_oldest[k] = w_starved[k] && (r_wait[k] == w_max_wait);
  end

  rr_arbiter #(.W(NLO), .PW(LPW)) u_rr (
    .i_req (w_lo_vld),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt)
  );

  // Equal-age starved requesters are separated in round-robin order.
  rr_arbiter #(.W(NLO), .PW(LPW)) u_rr_starve (
    .i_req (w_oldest),
    .i_ptr (r_ptr),
    .o_gnt (w_st_gnt)
  );

  always_comb begin
    w_grant = '0;
    if (|w_starved)          w_grant    = {w_st_gnt, 1'b0};
    else if (i_req_valid[0]) w_grant[0] = 1'b1;
    else                     w_grant    = {w_rr_gnt, 1'b0};
  end

  assign o_req_ready = i_rst_n ? w_grant : '0;
  assign w_xfer      = |w_grant;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_ptr_nxt  = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = i_req_addr[i];
        w_sel_data = i_req_data[i];
      end
    end
    for (int k = 0; k < NLO; k++)
      if (w_grant[k+1]) w_ptr_nxt = (k == NLO - 1) ? '0 : LPW'(k + 1);
  end

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_xfer) w_busy_nxt[w_sel_addr] = 1'b0;
    if (i_claim_valid && (i_claim_addr != '0)) w_busy_nxt[i_claim_addr] = 1'b1;
    if (i_flush) w_busy_nxt = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr  <= '0;
      r_we3  <= 1'b0;
      r_a3   <= '0;
      r_wd3  <= '0;
      r_busy <= '0;
      for (int k = 0; k < NLO; k++) r_wait[k] <= '0;
    end else begin
      r_ptr  <= w_ptr_nxt;
      r_busy <= w_busy_nxt;
      r_we3  <= w_xfer && (w_sel_addr != '0);
      if (w_xfer) begin
        r_a3  <= w_sel_addr;
        r_wd3 <= w_sel_data;
      end
      for (int k = 0; k < NLO; k++) begin
        if (!w_lo_vld[k] || w_grant[k+1]) r_wait[k] <= '0;
        else if (r_wait[k] != WAIT_MAX)   r_wait[k] <= r_wait[k] + 4'd1;
      end
    end
  end

  assign o_we3  = r_we3;
  assign o_a3   = r_a3;
  assign o_wd3  = r_wd3;
  assign o_busy = r_busy;
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port (A3/WD3/WE3) among several writeback requesters: the in-order pipeline writeback stage plus long-latency units such as load and mul/div. Requester 0 is the pipeline and has priority; the others are served round-robin, with a starvation guard. A 32-entry busy scoreboard is kept so decode can stall on pending destinations. The block sits between the writeback sources and the register file, and its outputs drive the register-file write port directly.

## Interface
- NUM_REQ, 3: number of write requesters, 2..8; index 0 is the pipeline writeback.
- AW, 5: register address width.
- DW, 32: write data width.
- STARVE_LIMIT, 4: cycles a low-priority requester may wait before pre-empting requester 0, 1..15.

- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  NUM_REQ  per-requester write request.
- i_req_addr  in  NUM_REQ x AW  destination register per requester.
- i_req_data  in  NUM_REQ x DW  write data per requester.
- o_req_ready  out  NUM_REQ  grant, at most one bit set per cycle.
- i_claim_valid  in  1  issue stage reserves a destination register.
- i_claim_addr  in  AW  register being reserved.
- i_flush  in  1  pipeline flush; clears the scoreboard.
- o_we3  out  1  register-file write enable.
- o_a3  out  AW  register-file write address.
- o_wd3  out  DW  register-file write data.
- o_busy  out  2**AW  scoreboard; bit r is set while register r has a pending writer.

## Operation
- Handshake:
  - A request transfers on a rising edge where valid and ready are both high.
  - The requester holds valid, addr and data stable until the transfer.
  - Ready is combinational from the current valids and arbitration state. It does not depend on the requester's own ready.
- Arbitration, evaluated each cycle:
  - If any low-priority requester's wait counter has reached STARVE_LIMIT, the oldest such requester is granted. Ties go to round-robin order.
  - Otherwise, if requester 0 is valid, requester 0 is granted.
  - Otherwise the round-robin pick among valid requesters 1..NUM_REQ-1 is granted. The search starts at the pointer.
- Round-robin pointer:
  - Advances to the index after the granted requester, only when a low-priority requester is granted.
  - Wraps from NUM_REQ-1 to 1.
  - Reset value is 1.
- Wait counters:
  - One 4-bit counter per low-priority requester.
  - Increments while the requester is valid and not granted; saturates at 15.
  - Clears on that requester's grant, or when it is not valid.
- Register-file write:
  - Address 0 requests are accepted and consumed, but produce o_we3=0.
  - Any other granted request registers o_we3=1 with o_a3/o_wd3 for exactly one cycle.
- Scoreboard:
  - A claim with i_claim_addr!=0 sets the corresponding busy bit. Bit 0 is never set.
  - An accepted write to r clears bit r.
  - Claim and write to the same r in the same cycle: the claim wins and the bit stays set, because the claim is the newer producer.
  - i_flush clears all bits and overrides claims and writes in that cycle. The write itself still reaches the register file.

## Timing
- Reset (async assert, sync deassert): o_we3=0, o_a3=0, o_wd3=0, o_busy=0, pointer=1, all wait counters=0. o_req_ready is combinationally 0 while i_rst_n is low.
- Latency:
  - A transfer at edge N drives o_we3/o_a3/o_wd3 during cycle N..N+1.
  - The register file captures the write on the falling edge inside that cycle.
  - A read issued at edge N+1 sees the new value.
- o_busy updates at the same edge as the transfer or claim. A stall decision in cycle N+1 reflects it.
- Throughput: one write per cycle. With no valid requester, o_we3=0 in the following cycle.
- Reset asserted mid-operation:
  - Any registered write is dropped and o_we3 goes low immediately.
  - Requesters must re-present their requests after reset.

## Structure
- Shared package regfile_pkg holds:
  - constants AW, DW, NUM_REGS=32;
  - typedef reg_addr_t (logic [AW-1:0]) and reg_data_t (logic [DW-1:0]);
  - typedef wr_req_t {addr, data}.
- Sub-module rr_arbiter, parameterised on width: round-robin pick with a pointer input and one-hot grant output. It is instantiated for requesters 1..NUM_REQ-1.
- Starvation counters, priority muxing, the output register and the scoreboard live in the top module.

## Test plan
- Reset: hold i_rst_n=0 with all requests valid -> o_req_ready=0, o_we3=0, o_busy=0. After release, first grant goes to req0.
- Priority: req0 and req1 valid continuously, STARVE_LIMIT=4 -> req0 is granted 4 cycles, then req1 once, then req0 resumes. o_a3/o_wd3 match the granted request one cycle later.
- Round-robin: req1 and req2 valid, req0 idle -> grants alternate 1,2,1,2 starting with 1. The pointer wraps 2->1.
- Address 0: req1 writes addr 0, data 0xDEADBEEF -> ready high, o_we3 stays 0, o_busy unchanged.
- Scoreboard: claim r5 -> o_busy[5]=1 next cycle. Write r5 plus a new claim r5 in the same cycle -> o_busy[5] stays 1. A later write to r5 alone clears it.
- Flush: busy bits for r3 and r7 set, i_flush with a simultaneous claim of r9 -> o_busy=0 next cycle.
